// File: rtl/cirno_pkg.sv
// Shared types and the instruction decode function for the Cirno decode stage.
// DECODER_ILLEGAL_TRAP_EN selects trap decoding of illegal encodings instead of NOP.
package cirno_pkg;

   typedef enum logic [2:0] {
      TypeTrap   = 3'd0,
      TypeAlu    = 3'd1,
      TypeNop    = 3'd2,
      TypeBranch = 3'd3,
      TypeMov    = 3'd4,
      TypeStore  = 3'd5,
      TypeLoad   = 3'd6
   } inst_type_e;

   localparam logic [3:0] FunctAnd = 4'b0011;
   localparam logic [3:0] FunctAdd = 4'b0101;
   localparam logic [3:0] FunctShl = 4'b0111;
   localparam logic [3:0] FunctShr = 4'b1110;

   localparam int unsigned FlagBranch  = 6;
   localparam int unsigned FlagBranchi = 5;
   localparam int unsigned FlagHiEn    = 4;
   localparam int unsigned FlagLoEn    = 3;
   localparam int unsigned FlagReadx   = 2;
   localparam int unsigned FlagYImm    = 1;
   localparam int unsigned FlagHalt    = 0;

   // imm is kept at 6 bits; sext says how it widens to the datapath width.
   typedef struct packed {
      inst_type_e  itype;
      logic [3:0]  funct;
      logic [1:0]  r1;
      logic [1:0]  r2;
      logic [5:0]  imm;
      logic        sext;
      logic [6:0]  flags;
      logic        illegal;
   } dec_t;

   function automatic dec_t decode_inst(input logic [8:0] inst, input logic cmp);
      dec_t       d;
      logic [3:0] f;
      d       = '0;
      d.itype = TypeNop;
      f       = inst[7:4];
      if (inst[8:6] == 3'b111) begin
         d.flags[FlagBranchi] = 1'b1;
         d.imm                = inst[5:0];
         d.sext               = 1'b1;
      end else if (inst[8]) begin
         d.r1  = inst[5:4];
         d.imm = {2'b00, inst[3:0]};
         if (inst[7:6] == 2'b10) begin
            d.itype            = TypeAlu;
            d.funct            = FunctAnd;
            d.flags[FlagReadx] = 1'b1;
            d.flags[FlagYImm]  = 1'b1;
         end else begin
            d.itype = TypeMov;
            if (inst[6]) d.flags[FlagHiEn] = 1'b1;
            else         d.flags[FlagLoEn] = 1'b1;
         end
      end else if (inst[7:6] == 2'b11) begin
         d.itype            = TypeAlu;
         d.funct            = inst[5] ? FunctShr : FunctShl;
         d.r1               = inst[4:3];
         d.imm              = {3'b000, inst[2:0]};
         d.flags[FlagReadx] = 1'b1;
         d.flags[FlagYImm]  = 1'b1;
      end else begin
         case (f)
            4'b1011: begin
               if (cmp) begin
                  d.flags[FlagBranchi] = 1'b1;
                  d.imm                = {{2{inst[3]}}, inst[3:0]};
                  d.sext               = 1'b1;
               end
            end
            4'b0000: begin
               unique case (inst[3:2])
                  2'b11: begin
                     d.itype            = TypeAlu;
                     d.funct            = FunctAdd;
                     d.imm              = 6'd1;
                     d.r1               = inst[1:0];
                     d.flags[FlagReadx] = 1'b1;
                     d.flags[FlagYImm]  = 1'b1;
                  end
                  2'b10: begin
                     d.itype             = TypeBranch;
                     d.r1                = inst[1:0];
                     d.flags[FlagReadx]  = 1'b1;
                     d.flags[FlagBranch] = 1'b1;
                  end
                  2'b01: begin
                     d.itype             = cmp ? TypeBranch : TypeNop;
                     d.r1                = inst[1:0];
                     d.flags[FlagReadx]  = 1'b1;
                     d.flags[FlagBranch] = cmp;
                  end
                  default: begin
                     if (inst[1]) begin
`ifdef DECODER_ILLEGAL_TRAP_EN
                        d.itype   = TypeTrap;
                        d.illegal = 1'b1;
`else
                        d.itype   = TypeNop;
`endif
                     end else begin
                        d.flags[FlagHalt] = inst[0];
                     end
                  end
               endcase
            end
            4'b1001, 4'b1000, 4'b0111: begin
               d.itype = (f == 4'b1001) ? TypeStore : (f == 4'b1000) ? TypeLoad : TypeMov;
               d.r1    = inst[3:2];
               d.r2    = inst[1:0];
            end
            default: begin
               d.itype = TypeAlu;
               d.funct = f;
               d.r1    = inst[3:2];
               d.r2    = inst[1:0];
            end
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/decoder_pipe_if.sv
// Fetch-side and issue-side handshake bundle of the decode stage.
interface decoder_pipe_if #(
   parameter int unsigned IMM_W = 8
);
   logic             in_valid;
   logic [8:0]       in_inst;
   logic             in_ready;
   logic             flush;
   logic             cmp;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       out_type;
   logic [3:0]       out_funct;
   logic [1:0]       out_r1;
   logic [1:0]       out_r2;
   logic [IMM_W-1:0] out_imm;
   logic [6:0]       out_flags;
   logic             done;
   logic             out_illegal;

   modport master (
      output in_valid, in_inst, flush, cmp, out_ready,
      input  in_ready, out_valid, out_type, out_funct, out_r1, out_r2, out_imm, out_flags,
             done, out_illegal
   );

   modport slave (
      input  in_valid, in_inst, flush, cmp, out_ready,
      output in_ready, out_valid, out_type, out_funct, out_r1, out_r2, out_imm, out_flags,
             done, out_illegal
   );
endinterface

// File: rtl/inst_fifo.sv
// Power-of-two instruction buffer with push/pop/flush; pointers carry a wrap bit.
module inst_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 9
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned Aw = $clog2(Depth);

   logic [Aw:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q[Aw-1:0]] = wdata_i;
            wr_ptr_d                = wr_ptr_q + {{Aw{1'b0}}, 1'b1};
         end
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + {{Aw{1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign rdata_o = mem_q[rd_ptr_q[Aw-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {Aw{1'b0}}});
endmodule

// File: rtl/decoder_pipe.sv
// Cirno decode stage: instruction FIFO feeding a registered decode bundle with sticky halt.
// DECODER_ILLEGAL_TRAP_EN makes illegal encodings trap and halt instead of decoding as NOP.
module decoder_pipe
   import cirno_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned IMM_W      = 8
) (
   input logic           clk,
   input logic           rst,
   decoder_pipe_if.slave bus
);
   typedef enum logic [0:0] {StRun, StHalted} state_e;

   state_e            state_q, state_d;
   dec_t              bundle_q, bundle_d;
   logic              out_valid_q, out_valid_d;
   logic              fifo_full, fifo_empty;
   logic              in_ready, push, pop, take, halt_take;
   logic [8:0]        fifo_rdata;
   logic signed [5:0] imm_s;

   inst_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (9)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (bus.flush),
      .push_i  (push),
      .wdata_i (bus.in_inst),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      in_ready  = (state_q == StRun) && !fifo_full && !rst;
      push      = bus.in_valid && in_ready && !bus.flush;
      take      = out_valid_q && bus.out_ready;
      // A flush discards a pending halt even if issue consumes it on the same edge.
      halt_take = take && !bus.flush && (bundle_q.flags[FlagHalt] || bundle_q.illegal);
      // Nothing may follow a consumed halt into the decode register.
      pop       = (state_q == StRun) && !fifo_empty && (!out_valid_q || bus.out_ready) &&
                  !halt_take && !bus.flush;
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      bundle_d    = bundle_q;
      if (halt_take) state_d = StHalted;
      if (take) out_valid_d = 1'b0;
      if (pop) begin
         out_valid_d = 1'b1;
         bundle_d    = decode_inst(fifo_rdata, bus.cmp);
      end
      if (bus.flush) out_valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         bundle_q    <= bundle_d;
      end
   end

   assign imm_s         = signed'(bundle_q.imm);
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_type  = bundle_q.itype;
   assign bus.out_funct = bundle_q.funct;
   assign bus.out_r1    = bundle_q.r1;
   assign bus.out_r2    = bundle_q.r2;
   assign bus.out_imm   = bundle_q.sext ? IMM_W'(imm_s) : IMM_W'(bundle_q.imm);
   assign bus.out_flags = bundle_q.flags;
   assign bus.done      = (state_q == StHalted);
`ifdef DECODER_ILLEGAL_TRAP_EN
   assign bus.out_illegal = bundle_q.illegal;
`else
   assign bus.out_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_decoder_pipe.sv
// Directed self-checking bench for decoder_pipe with hand-computed decode expectations.
module tb_decoder_pipe;
   localparam int unsigned FifoDepth = 2;
   localparam int unsigned ImmW      = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   decoder_pipe_if #(.IMM_W(ImmW)) bus ();

   decoder_pipe #(
      .FIFO_DEPTH (FifoDepth),
      .IMM_W      (ImmW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string      name;
      logic [8:0] inst;
      logic       cmp;
      logic [2:0] typ;
      logic [3:0] funct;
      logic [1:0] r1;
      logic [1:0] r2;
      logic [7:0] imm;
      logic [6:0] flags;
   } vec_t;

   vec_t vecs[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [8:0] inst);
      bus.in_valid = 1'b1;
      bus.in_inst  = inst;
      tick();
      bus.in_valid = 1'b0;
   endtask

   function automatic logic [31:0] snap();
      return {5'b0, bus.out_type, bus.out_funct, bus.out_r1, bus.out_r2, bus.out_imm,
              bus.out_flags, bus.out_illegal};
   endfunction

   function automatic logic [31:0] exp_b(input logic [2:0] typ, input logic [3:0] funct,
                                         input logic [1:0] r1, input logic [1:0] r2,
                                         input logic [7:0] imm, input logic [6:0] flags,
                                         input logic ill);
      return {5'b0, typ, funct, r1, r2, imm, flags, ill};
   endfunction

   task automatic add_vec(input string name, input logic [8:0] inst, input logic cmp,
                          input logic [2:0] typ, input logic [3:0] funct, input logic [1:0] r1,
                          input logic [1:0] r2, input logic [7:0] imm, input logic [6:0] flags);
      vec_t v;
      v.name = name; v.inst = inst; v.cmp = cmp; v.typ = typ; v.funct = funct;
      v.r1 = r1; v.r2 = r2; v.imm = imm; v.flags = flags;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_inst  = '0;
      bus.flush    = 1'b0;
      bus.cmp      = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //       name        inst          cmp typ funct    r1 r2 imm    flags
      add_vec("movhi",    9'b101010110, 0, 4, 4'b0000, 1, 0, 8'h06, 7'b0010000);
      add_vec("jmpi",     9'b111111110, 0, 2, 4'b0000, 0, 0, 8'hFE, 7'b0100000);
      add_vec("beqi_nt",  9'b010110011, 0, 2, 4'b0000, 0, 0, 8'h00, 7'b0000000);
      add_vec("beqi_t",   9'b010110011, 1, 2, 4'b0000, 0, 0, 8'h03, 7'b0100000);
      add_vec("beqi_neg", 9'b010111100, 1, 2, 4'b0000, 0, 0, 8'hFC, 7'b0100000);
      add_vec("movli",    9'b100101111, 0, 4, 4'b0000, 2, 0, 8'h0F, 7'b0001000);
      add_vec("andi",     9'b110110101, 0, 1, 4'b0011, 3, 0, 8'h05, 7'b0000110);
      add_vec("shri",     9'b011110101, 0, 1, 4'b1110, 2, 0, 8'h05, 7'b0000110);
      add_vec("shli",     9'b011001011, 0, 1, 4'b0111, 1, 0, 8'h03, 7'b0000110);
      add_vec("incr",     9'b000001110, 0, 1, 4'b0101, 2, 0, 8'h01, 7'b0000110);
      add_vec("jmp",      9'b000001001, 0, 3, 4'b0000, 1, 0, 8'h00, 7'b1000100);
      add_vec("beq_nt",   9'b000000111, 0, 2, 4'b0000, 3, 0, 8'h00, 7'b0000100);
      add_vec("beq_t",    9'b000000111, 1, 3, 4'b0000, 3, 0, 8'h00, 7'b1000100);
      add_vec("store",    9'b010011001, 0, 5, 4'b0000, 2, 1, 8'h00, 7'b0000000);
      add_vec("load",     9'b010000110, 0, 6, 4'b0000, 1, 2, 8'h00, 7'b0000000);
      add_vec("sh",       9'b001111100, 0, 4, 4'b0000, 3, 0, 8'h00, 7'b0000000);
      add_vec("add",      9'b001010001, 0, 1, 4'b0101, 0, 1, 8'h00, 7'b0000000);
      add_vec("nop",      9'b000000000, 0, 2, 4'b0000, 0, 0, 8'h00, 7'b0000000);
      add_vec("f0010",    9'b000101110, 0, 1, 4'b0010, 3, 2, 8'h00, 7'b0000000);

      // Reset state
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_inst  = '0;
      bus.flush    = 1'b0;
      bus.cmp      = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_bundle", snap(), 32'd0);
      rst = 1'b0;
      #1;
      check_eq("run_in_ready", 32'(bus.in_ready), 32'd1);

      // Decode vectors, one word at a time with issue always ready
      foreach (vecs[i]) begin
         bus.cmp = vecs[i].cmp;
         push1(vecs[i].inst);
         check_eq({vecs[i].name, "_lat"}, 32'(bus.out_valid), 32'd0);
         tick();
         check_eq({vecs[i].name, "_valid"}, 32'(bus.out_valid), 32'd1);
         check_eq({vecs[i].name, "_bundle"}, snap(),
                  exp_b(vecs[i].typ, vecs[i].funct, vecs[i].r1, vecs[i].r2, vecs[i].imm,
                        vecs[i].flags, 1'b0));
      end
      bus.cmp = 1'b0;
      tick();
      check_eq("drain_valid", 32'(bus.out_valid), 32'd0);

      // Backpressure: three words fill decode register plus FIFO
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_inst   = 9'b010011001;
      tick();
      check_eq("bp_ready1", 32'(bus.in_ready), 32'd1);
      bus.in_inst = 9'b010000110;
      tick();
      check_eq("bp_ready2", 32'(bus.in_ready), 32'd1);
      check_eq("bp_valid2", 32'(bus.out_valid), 32'd1);
      bus.in_inst = 9'b001010001;
      tick();
      bus.in_valid = 1'b0;
      check_eq("bp_full_ready", 32'(bus.in_ready), 32'd0);
      check_eq("bp_w0", snap(), exp_b(5, 4'b0000, 2, 1, 8'h00, 7'b0, 1'b0));
      tick();
      check_eq("bp_hold_w0", snap(), exp_b(5, 4'b0000, 2, 1, 8'h00, 7'b0, 1'b0));
      check_eq("bp_hold_ready", 32'(bus.in_ready), 32'd0);
      bus.out_ready = 1'b1;
      tick();
      check_eq("bp_w1_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_w1", snap(), exp_b(6, 4'b0000, 1, 2, 8'h00, 7'b0, 1'b0));
      check_eq("bp_ready_back", 32'(bus.in_ready), 32'd1);
      tick();
      check_eq("bp_w2_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_w2", snap(), exp_b(1, 4'b0101, 0, 1, 8'h00, 7'b0, 1'b0));
      tick();
      check_eq("bp_empty", 32'(bus.out_valid), 32'd0);

      // Flush with a simultaneous push drops everything
      bus.out_ready = 1'b0;
      push1(9'b010011001);
      push1(9'b010000110);
      check_eq("fl_pre_valid", 32'(bus.out_valid), 32'd1);
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_inst  = 9'b001010001;
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check_eq("fl_valid", 32'(bus.out_valid), 32'd0);
      check_eq("fl_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;
      tick();
      tick();
      check_eq("fl_stays_empty", 32'(bus.out_valid), 32'd0);

      // Flush discards a pending halt
      bus.out_ready = 1'b0;
      push1(9'b000000001);
      tick();
      check_eq("flh_halt", snap(), exp_b(2, 4'b0000, 0, 0, 8'h00, 7'b0000001, 1'b0));
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.flush = 1'b0;
      check_eq("flh_valid", 32'(bus.out_valid), 32'd0);
      check_eq("flh_done", 32'(bus.done), 32'd0);
      push1(9'b000000000);
      tick();
      check_eq("flh_run_valid", 32'(bus.out_valid), 32'd1);
      check_eq("flh_run_done", 32'(bus.done), 32'd0);
      tick();

      // Illegal encoding
      push1(9'b000000010);
      tick();
`ifdef DECODER_ILLEGAL_TRAP_EN
      check_eq("ill_bundle", snap(), exp_b(0, 4'b0000, 0, 0, 8'h00, 7'b0, 1'b1));
      tick();
      check_eq("ill_done", 32'(bus.done), 32'd1);
`else
      check_eq("ill_bundle", snap(), exp_b(2, 4'b0000, 0, 0, 8'h00, 7'b0, 1'b0));
      tick();
      check_eq("ill_done", 32'(bus.done), 32'd0);
`endif
      do_reset();

      // Halt: consumed halt stops the pipe, trailing add never appears
      bus.out_ready = 1'b0;
      push1(9'b000000001);
      push1(9'b001010001);
      check_eq("h_bundle", snap(), exp_b(2, 4'b0000, 0, 0, 8'h00, 7'b0000001, 1'b0));
      bus.out_ready = 1'b1;
      tick();
      check_eq("h_done", 32'(bus.done), 32'd1);
      check_eq("h_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("h_valid", 32'(bus.out_valid), 32'd0);
      tick();
      tick();
      tick();
      check_eq("h_no_pop", 32'(bus.out_valid), 32'd0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check_eq("h_flush_done", 32'(bus.done), 32'd1);
      rst = 1'b1;
      tick();
      check_eq("h_rst_done", 32'(bus.done), 32'd0);
      check_eq("h_rst_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      #1;
      check_eq("h_run_ready", 32'(bus.in_ready), 32'd1);
      tick();
      tick();
      check_eq("h_fifo_cleared", 32'(bus.out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
